// File: rtl/uart_tx_fifo_param.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_param
//
// Circular transmit FIFO between a CPU write port and a UART transmitter.
// The CPU pushes one word per rising edge of a level-held write strobe. The
// read side hands the oldest word to the transmitter with a one-cycle start
// pulse. It pops that word only after the transmitter reports completion
// with a rising edge on tx_done.
//
// Parameters
//   DATA_BITS  width of each stored word
//   ADDR_BITS  log2 of the FIFO depth (DEPTH = 2**ADDR_BITS)
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   w_data    in   CPU write data, sampled on the wr rising edge
//   wr        in   CPU write strobe (level, may be held)
//   flush     in   synchronous clear of pointers, count and read FSM
//   tx_done   in   transmitter completion (level, may be held)
//   d_in      out  word presented to the transmitter
//   tx_start  out  one-cycle start pulse to the transmitter
//   tx_full   out  occupancy equals DEPTH
//   tx_empty  out  occupancy equals zero
//   level     out  current occupancy
//   overflow  out  one-cycle pulse when a write edge is rejected (FIFO full)
// -----------------------------------------------------------------------------
module uart_tx_fifo_param #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] w_data,
  input  logic                 wr,
  input  logic                 flush,
  input  logic                 tx_done,
  output logic [DATA_BITS-1:0] d_in,
  output logic                 tx_start,
  output logic                 tx_full,
  output logic                 tx_empty,
  output logic [ADDR_BITS:0]   level,
  output logic                 overflow
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  // Occupancy value that means "full": the extra count bit set, the rest clear.
  localparam logic [ADDR_BITS:0] FULL_COUNT = {1'b1, {ADDR_BITS{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_q [DEPTH];

  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q,  count_d;
  logic                 overflow_q, overflow_d;

  state_e               state_q;
  logic [DATA_BITS-1:0] d_in_q;
  logic                 tx_start_q;

  // Edge-detect history for the two level-held handshake inputs.
  logic                 wr_q;
  logic                 tx_done_q;

  logic                 wr_ev;
  logic                 done_ev;
  logic                 full;
  logic                 push;
  logic                 pop;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  // Only one word is pushed per wr rising edge, however long wr stays high. A
  // pop in the same cycle does not free a slot for this write, because full is
  // taken from the count before the clock edge. flush discards both events.
  assign wr_ev   = wr & ~wr_q;
  assign done_ev = tx_done & ~tx_done_q;
  assign full    = (count_q == FULL_COUNT);
  assign push    = wr_ev & ~full & ~flush;
  assign pop     = (state_q == ST_WAIT) & done_ev & ~flush;

  // ---------------------------------------------------------------------------
  // Pointer / occupancy next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch, so partial
    // assignment cannot infer a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly ADDR_BITS wide, so the increment wraps at DEPTH.
      if (push) wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);

      // A push and a pop in the same cycle leave the count unchanged.
      unique case ({push, pop})
        2'b10:   count_d = count_q + (ADDR_BITS+1)'(1);
        2'b01:   count_d = count_q - (ADDR_BITS+1)'(1);
        default: count_d = count_q;
      endcase

      overflow_d = wr_ev & full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Edge history resets high, so a level still held when reset is
      // released does not create a push or a completion event.
      wr_q       <= 1'b1;
      tx_done_q  <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples values from before the clock edge.
      wr_q       <= wr;
      tx_done_q  <= tx_done;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Word storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset. Only words between rd_ptr and wr_ptr are
  // ever read, so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= w_data;
  end

  // ---------------------------------------------------------------------------
  // Read FSM: load word, pulse tx_start, wait for completion, pop
  // ---------------------------------------------------------------------------
  // IDLE tests the count from before the edge. A word pushed at edge k is
  // therefore loaded at edge k+1, and tx_start is high for the cycle after
  // that edge. A push cannot overwrite the slot at rd_ptr while count is
  // non-zero, because that slot is only reused after a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      d_in_q     <= '0;
      tx_start_q <= 1'b0;
    end else if (flush) begin
      // A transmission in flight is abandoned without a pop. d_in keeps the
      // last word so the transmitter's input does not glitch.
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          tx_start_q <= 1'b0;
          if (count_q != '0) begin
            d_in_q     <= mem_q[rd_ptr_q];
            tx_start_q <= 1'b1;
            state_q    <= ST_SEND;
          end
        end
        ST_SEND: begin
          // tx_start was raised on entry, so it lasts exactly one cycle.
          tx_start_q <= 1'b0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          tx_start_q <= 1'b0;
          // The pointer and count update for this pop is in the datapath.
          if (done_ev) state_q <= ST_IDLE;
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign d_in     = d_in_q;
  assign tx_start = tx_start_q;
  assign overflow = overflow_q;
  assign level    = count_q;
  assign tx_full  = full;
  assign tx_empty = (count_q == '0);

endmodule
